// File: rtl/trans_ledger_engine.sv
// Account ledger engine: searches a banked {id, balance} store with LANES parallel
// compares, allocates unknown accounts, checks funds/overflow and forwards or rejects.
module trans_ledger_engine #(
   parameter int ID_W      = 48,
   parameter int AMT_W     = 22,
   parameter int BAL_W     = 24,
   parameter int DEPTH     = 16384,
   parameter int LANES     = 4,
   parameter int MAX_ACCTS = 10000,
   parameter int INIT_BAL  = 100,
   parameter int DATA_W    = 2*ID_W+AMT_W+10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       data_i,
   input  logic                    valid_i,
   output logic                    ack_o,
   output logic [DATA_W-1:0]       data_o,
   output logic                    valid_o,
   output logic                    reject_o,
   output logic [1:0]              reject_code_o,
   output logic                    busy_o,
   output logic [$clog2(DEPTH):0]  accts_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int ACC_W = IDX_W + 1;
   localparam int LSH   = $clog2(LANES);
   localparam int ROW_W = IDX_W - LSH;
   localparam int ROWS  = DEPTH / LANES;
   localparam int ENT_W = ID_W + BAL_W;
   localparam int CW    = ((AMT_W > BAL_W) ? AMT_W : BAL_W) + 2;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEARCH  = 3'd1;
   localparam logic [2:0] S_ALLOC   = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_WRITE_S = 3'd4;
   localparam logic [2:0] S_WRITE_R = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ack_q, ack_d, valid_q, valid_d, reject_q, reject_d;
   logic [1:0]        code_q, code_d;
   logic [ACC_W-1:0]  accts_q, accts_d, r_q, r_d;
   logic              cmp_q, cmp_d;
   logic [ROW_W-1:0]  cmp_row_q, cmp_row_d;
   logic              s_found_q, s_found_d, r_found_q, r_found_d;
   logic [IDX_W-1:0]  s_idx_q, s_idx_d, r_idx_q, r_idx_d;
   logic [BAL_W-1:0]  s_bal_q, s_bal_d, r_bal_q, r_bal_d;
   logic              wr_s_q, wr_s_d, wr_r_q, wr_r_d;

   logic [ID_W-1:0]   snd, rcv;
   logic [AMT_W-1:0]  amt;
   assign snd = data_q[DATA_W-1 -: ID_W];
   assign rcv = data_q[DATA_W-ID_W-1 -: ID_W];
   assign amt = data_q[AMT_W+9:10];

   // Ledger storage: entry i lives in bank i%LANES at row i/LANES.
   logic [LANES-1:0][ENT_W-1:0] rd_data;
   logic                        rd_en, wr_en;
   logic [ROW_W-1:0]            rd_row, wr_row;
   logic [IDX_W-1:0]            wr_idx;
   logic [ENT_W-1:0]            wr_data;
   logic [LANES-1:0]            wr_sel;

   always_comb begin
      for (int b = 0; b < LANES; b++) begin
         wr_sel[b] = wr_en && ((int'(wr_idx) % LANES) == b);
      end
   end
   assign wr_row = wr_idx[IDX_W-1:LSH];

   for (genvar b = 0; b < LANES; b++) begin : g_bank
      logic [ENT_W-1:0] mem [ROWS];
      logic [ENT_W-1:0] rd_q;
      always_ff @(posedge clk) begin
         if (wr_sel[b]) mem[wr_row] <= wr_data;
         if (rd_en) rd_q <= mem[rd_row];
      end
      assign rd_data[b] = rd_q;
   end

   // Lane compare on the row returned this cycle; entries at or above accts never match.
   logic             s_m, r_m;
   logic [IDX_W-1:0] s_m_idx, r_m_idx, li;
   logic [BAL_W-1:0] s_m_bal, r_m_bal;
   always_comb begin
      s_m = 1'b0; r_m = 1'b0;
      s_m_idx = '0; r_m_idx = '0; s_m_bal = '0; r_m_bal = '0; li = '0;
      for (int l = 0; l < LANES; l++) begin
         li = (IDX_W'(cmp_row_q) << LSH) + IDX_W'(l);
         if (ACC_W'(li) < accts_q) begin
            if (!s_m && rd_data[l][ENT_W-1 -: ID_W] == snd) begin
               s_m = 1'b1; s_m_idx = li; s_m_bal = rd_data[l][BAL_W-1:0];
            end
            if (!r_m && rd_data[l][ENT_W-1 -: ID_W] == rcv) begin
               r_m = 1'b1; r_m_idx = li; r_m_bal = rd_data[l][BAL_W-1:0];
            end
         end
      end
   end

   logic [ACC_W-1:0] rows_total, needed;
   logic             s_hit, r_hit, search_done;
   logic             self_tx, s_new, r_new, full, insuf, ovf;
   logic [IDX_W-1:0] a_s_idx, a_r_idx;
   logic [BAL_W-1:0] a_s_bal, a_r_bal;

   assign rows_total  = (accts_q + ACC_W'(LANES-1)) >> LSH;
   assign s_hit       = s_found_q | (cmp_q & s_m);
   assign r_hit       = r_found_q | (cmp_q & r_m);
   assign search_done = (s_hit & r_hit) | (r_q >= rows_total);
   assign rd_en       = (state_q == S_SEARCH) && !search_done;
   assign rd_row      = r_q[ROW_W-1:0];

   assign self_tx = (snd == rcv);
   assign s_new   = !s_found_q;
   assign r_new   = !self_tx && !r_found_q;
   assign needed  = ACC_W'(s_new) + ACC_W'(r_new);
   assign full    = (accts_q + needed) > ACC_W'(MAX_ACCTS);
   assign a_s_idx = s_new ? accts_q[IDX_W-1:0] : s_idx_q;
   assign a_r_idx = self_tx ? a_s_idx : (r_new ? accts_q[IDX_W-1:0] + IDX_W'(s_new) : r_idx_q);
   assign a_s_bal = s_new ? BAL_W'(INIT_BAL) : s_bal_q;
   assign a_r_bal = self_tx ? a_s_bal : (r_new ? BAL_W'(INIT_BAL) : r_bal_q);
   assign insuf   = CW'(amt) > CW'(a_s_bal);
   assign ovf     = !self_tx && ((CW'(a_r_bal) + CW'(amt)) >= (CW'(1) << BAL_W));

   assign wr_en   = (state_q == S_WRITE_S) || (state_q == S_WRITE_R);
   assign wr_idx  = (state_q == S_WRITE_R) ? r_idx_q : s_idx_q;
   assign wr_data = (state_q == S_WRITE_R) ? {rcv, r_bal_q} : {snd, s_bal_q};

   always_comb begin
      state_d = state_q; data_d = data_q; accts_d = accts_q;
      ack_d = 1'b0; valid_d = 1'b0; reject_d = 1'b0; code_d = 2'd0;
      r_d = r_q; cmp_d = cmp_q; cmp_row_d = cmp_row_q;
      s_found_d = s_found_q; r_found_d = r_found_q;
      s_idx_d = s_idx_q; r_idx_d = r_idx_q; s_bal_d = s_bal_q; r_bal_d = r_bal_q;
      wr_s_d = wr_s_q; wr_r_d = wr_r_q;
      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               data_d = data_i; ack_d = 1'b1; state_d = S_SEARCH;
               r_d = '0; cmp_d = 1'b0; s_found_d = 1'b0; r_found_d = 1'b0;
               if (data_i[9]) accts_d = '0;
            end
         end
         S_SEARCH: begin
            if (cmp_q && s_m && !s_found_q) begin
               s_found_d = 1'b1; s_idx_d = s_m_idx; s_bal_d = s_m_bal;
            end
            if (cmp_q && r_m && !r_found_q) begin
               r_found_d = 1'b1; r_idx_d = r_m_idx; r_bal_d = r_m_bal;
            end
            if (search_done) begin
               state_d = S_ALLOC;
            end else begin
               r_d = r_q + ACC_W'(1); cmp_row_d = rd_row; cmp_d = 1'b1;
            end
         end
         S_ALLOC: begin
            // Outcome is registered here so the pulse lands in the following cycle.
            if (full) begin
               reject_d = 1'b1; code_d = 2'd3; state_d = S_IDLE;
            end else begin
               accts_d = accts_q + needed;
               s_idx_d = a_s_idx; r_idx_d = a_r_idx;
               state_d = S_CHECK;
               if (insuf || ovf) begin
                  reject_d = 1'b1; code_d = insuf ? 2'd1 : 2'd2;
                  s_bal_d = a_s_bal; r_bal_d = a_r_bal;
                  wr_s_d = s_new; wr_r_d = r_new;
               end else begin
                  valid_d = 1'b1;
                  wr_s_d = 1'b1; wr_r_d = !self_tx;
                  s_bal_d = self_tx ? a_s_bal : a_s_bal - BAL_W'(amt);
                  r_bal_d = a_r_bal + BAL_W'(amt);
               end
            end
         end
         S_CHECK:   state_d = wr_s_q ? S_WRITE_S : (wr_r_q ? S_WRITE_R : S_IDLE);
         S_WRITE_S: state_d = wr_r_q ? S_WRITE_R : S_IDLE;
         S_WRITE_R: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE; data_q <= '0; accts_q <= '0;
         ack_q <= 1'b0; valid_q <= 1'b0; reject_q <= 1'b0; code_q <= 2'd0;
         r_q <= '0; cmp_q <= 1'b0; cmp_row_q <= '0;
         s_found_q <= 1'b0; r_found_q <= 1'b0;
         s_idx_q <= '0; r_idx_q <= '0; s_bal_q <= '0; r_bal_q <= '0;
         wr_s_q <= 1'b0; wr_r_q <= 1'b0;
      end else begin
         state_q <= state_d; data_q <= data_d; accts_q <= accts_d;
         ack_q <= ack_d; valid_q <= valid_d; reject_q <= reject_d; code_q <= code_d;
         r_q <= r_d; cmp_q <= cmp_d; cmp_row_q <= cmp_row_d;
         s_found_q <= s_found_d; r_found_q <= r_found_d;
         s_idx_q <= s_idx_d; r_idx_q <= r_idx_d; s_bal_q <= s_bal_d; r_bal_q <= r_bal_d;
         wr_s_q <= wr_s_d; wr_r_q <= wr_r_d;
      end
   end

   assign ack_o         = ack_q;
   assign data_o        = data_q;
   assign valid_o       = valid_q;
   assign reject_o      = reject_q;
   assign reject_code_o = code_q;
   assign busy_o        = (state_q != S_IDLE);
   assign accts_o       = accts_q;

endmodule

// File: tb/tb_trans_ledger_engine.sv
// Bench for trans_ledger_engine: three configurations driven from one directed sequence,
// outcomes predicted by a queue-based ledger model.
module tb_trans_ledger_engine;

   localparam int ID_W   = 48;
   localparam int AMT_W  = 22;
   localparam int DATA_W = 2*ID_W + AMT_W + 10;
   localparam int ACC_W  = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0]            data_i = '0;
   logic [2:0]                   valid_v = '0;
   logic [2:0]                   ack_v, vo_v, rj_v, busy_v;
   logic [2:0][1:0]              code_v;
   logic [2:0][ACC_W-1:0]        accts_v;
   logic [2:0][DATA_W-1:0]       dout_v;

   trans_ledger_engine u0 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_v[0]), .ack_o(ack_v[0]),
      .data_o(dout_v[0]), .valid_o(vo_v[0]), .reject_o(rj_v[0]), .reject_code_o(code_v[0]),
      .busy_o(busy_v[0]), .accts_o(accts_v[0]));

   trans_ledger_engine #(.BAL_W(8), .INIT_BAL(200)) u1 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_v[1]), .ack_o(ack_v[1]),
      .data_o(dout_v[1]), .valid_o(vo_v[1]), .reject_o(rj_v[1]), .reject_code_o(code_v[1]),
      .busy_o(busy_v[1]), .accts_o(accts_v[1]));

   trans_ledger_engine #(.MAX_ACCTS(3)) u2 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_v[2]), .ack_o(ack_v[2]),
      .data_o(dout_v[2]), .valid_o(vo_v[2]), .reject_o(rj_v[2]), .reject_code_o(code_v[2]),
      .busy_o(busy_v[2]), .accts_o(accts_v[2]));

   int checks = 0;
   int errors = 0;

   // Reference ledger: index in the queue is the account's allocation order.
   logic [ID_W-1:0] m_id[$];
   longint          m_bal[$];
   int              cur_max = 10000;
   int              cur_balw = 24;
   longint          cur_init = 100;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_id(input logic [ID_W-1:0] id);
      for (int i = 0; i < m_id.size(); i++) if (m_id[i] == id) return i;
      return -1;
   endfunction

   // Predicts reject code (0 = accepted) and capture-to-pulse latency, and updates the ledger.
   task automatic model_txn(input logic [ID_W-1:0] s, input logic [ID_W-1:0] r, input int amt,
                            input bit blk, output int code, output int lat);
      int ps, pr, n, need;
      bit self_tx;
      if (blk) begin m_id.delete(); m_bal.delete(); end
      n = m_id.size();
      self_tx = (s == r);
      ps = find_id(s);
      pr = self_tx ? ps : find_id(r);
      if (ps >= 0 && pr >= 0) lat = ((ps > pr) ? ps : pr) / 4 + 2 + 2;
      else if (n == 0)        lat = 1 + 2;
      else                    lat = (n + 3) / 4 + 1 + 2;
      need = ((ps < 0) ? 1 : 0) + ((!self_tx && pr < 0) ? 1 : 0);
      if (n + need > cur_max) begin code = 3; return; end
      if (ps < 0) begin m_id.push_back(s); m_bal.push_back(cur_init); ps = n; end
      if (self_tx) pr = ps;
      else if (pr < 0) begin m_id.push_back(r); m_bal.push_back(cur_init); pr = m_id.size() - 1; end
      if (longint'(amt) > m_bal[ps]) code = 1;
      else if (!self_tx && (m_bal[pr] + longint'(amt) >= (longint'(1) << cur_balw))) code = 2;
      else begin
         code = 0;
         if (!self_tx) begin m_bal[ps] -= longint'(amt); m_bal[pr] += longint'(amt); end
      end
   endtask

   task automatic do_txn(input int d, input logic [ID_W-1:0] s, input logic [ID_W-1:0] r,
                         input int amt, input bit blk, input string tag);
      logic [DATA_W-1:0] w;
      int code, lat, k;
      bit seen;
      w = {s, r, AMT_W'(amt), blk, 9'($urandom)};
      model_txn(s, r, amt, blk, code, lat);
      data_i = w;
      valid_v[d] = 1'b1;
      @(posedge clk); #1;
      valid_v = '0;
      chk({tag, ".ack"}, DATA_W'(ack_v[d]), DATA_W'(1));
      chk({tag, ".data"}, dout_v[d], w);
      k = 1; seen = 1'b0;
      while (!seen && k < 200) begin
         if (vo_v[d] || rj_v[d]) seen = 1'b1;
         else begin @(posedge clk); #1; k++; end
      end
      chk({tag, ".latency"}, DATA_W'(k), DATA_W'(lat));
      chk({tag, ".valid"}, DATA_W'(vo_v[d]), DATA_W'(code == 0));
      chk({tag, ".reject"}, DATA_W'(rj_v[d]), DATA_W'(code != 0));
      chk({tag, ".code"}, DATA_W'(code_v[d]), DATA_W'(code));
      @(posedge clk); #1;
      chk({tag, ".pulse_end"}, DATA_W'(vo_v[d] | rj_v[d]), DATA_W'(0));
      k = 0;
      while (busy_v[d] && k < 50) begin @(posedge clk); #1; k++; end
      chk({tag, ".idle"}, DATA_W'(busy_v[d]), DATA_W'(0));
      chk({tag, ".accts"}, DATA_W'(accts_v[d]), DATA_W'(m_id.size()));
   endtask

   task automatic chk_zero(input int d, input string tag);
      chk({tag, ".ack"}, DATA_W'(ack_v[d]), DATA_W'(0));
      chk({tag, ".valid"}, DATA_W'(vo_v[d]), DATA_W'(0));
      chk({tag, ".reject"}, DATA_W'(rj_v[d]), DATA_W'(0));
      chk({tag, ".code"}, DATA_W'(code_v[d]), DATA_W'(0));
      chk({tag, ".busy"}, DATA_W'(busy_v[d]), DATA_W'(0));
      chk({tag, ".accts"}, DATA_W'(accts_v[d]), DATA_W'(0));
      chk({tag, ".data"}, dout_v[d], DATA_W'(0));
   endtask

   localparam logic [ID_W-1:0] A = 48'h0000_0000_000A;
   localparam logic [ID_W-1:0] B = 48'h0000_0000_000B;
   localparam logic [ID_W-1:0] C = 48'h0000_0000_000C;
   localparam logic [ID_W-1:0] D = 48'h0000_0000_000D;

   initial begin
      logic [ID_W-1:0] pool [10];
      logic [DATA_W-1:0] w;
      #2;
      chk_zero(0, "rst0"); chk_zero(1, "rst1"); chk_zero(2, "rst2");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Default configuration: funds, exact-balance and allocation-on-reject cases.
      do_txn(0, A, B, 30, 1'b1, "ab30");
      do_txn(0, B, A, 130, 1'b0, "ba130");
      do_txn(0, A, B, 130, 1'b0, "ab130");
      do_txn(0, A, B, 71, 1'b0, "ab71");
      do_txn(0, A, B, 70, 1'b0, "ab70");
      do_txn(0, A, C, 1, 1'b0, "ac1");
      do_txn(0, C, A, 100, 1'b0, "ca100");
      do_txn(0, A, A, 50, 1'b0, "aa50");
      do_txn(0, A, A, 101, 1'b0, "aa101");

      // Seven accounts across two rows; transfer between entries 0 and 6.
      do_txn(0, 48'h100, 48'h101, 0, 1'b1, "l7a");
      do_txn(0, 48'h102, 48'h103, 0, 1'b0, "l7b");
      do_txn(0, 48'h104, 48'h105, 0, 1'b0, "l7c");
      do_txn(0, 48'h106, 48'h100, 0, 1'b0, "l7d");
      do_txn(0, 48'h100, 48'h106, 10, 1'b0, "l7x");
      do_txn(0, 48'h106, 48'h106, 50, 1'b0, "l7self");

      for (int i = 0; i < 10; i++) pool[i] = ID_W'({$urandom(), $urandom()});
      for (int i = 0; i < 40; i++) begin
         do_txn(0, pool[$urandom_range(0, 9)], pool[$urandom_range(0, 9)],
                int'($urandom_range(0, 160)), (i == 0) || ($urandom_range(0, 15) == 0), "rnd");
      end

      // Narrow balances: receiver overflow boundary at 2^8.
      cur_balw = 8; cur_init = 200;
      do_txn(1, A, B, 60, 1'b1, "ovf60");
      do_txn(1, A, B, 56, 1'b0, "ovf56");
      do_txn(1, A, B, 55, 1'b0, "ovf55");
      do_txn(1, B, A, 111, 1'b0, "ovf111");
      do_txn(1, B, A, 110, 1'b0, "ovf110");
      do_txn(1, B, A, 300, 1'b0, "big300");

      // Allocation limit of three accounts.
      cur_balw = 24; cur_init = 100; cur_max = 3;
      do_txn(2, A, B, 10, 1'b1, "full_ab");
      do_txn(2, C, D, 10, 1'b0, "full_cd");
      do_txn(2, C, A, 10, 1'b0, "full_ca");
      do_txn(2, D, A, 10, 1'b0, "full_da");
      do_txn(2, B, C, 50, 1'b0, "full_bc");

      // Reset during a search abandons the transaction.
      cur_max = 10000;
      do_txn(0, 48'h200, 48'h201, 0, 1'b1, "pre_a");
      do_txn(0, 48'h202, 48'h203, 0, 1'b0, "pre_b");
      do_txn(0, 48'h204, 48'h205, 0, 1'b0, "pre_c");
      do_txn(0, 48'h206, 48'h207, 0, 1'b0, "pre_d");
      w = {48'h300, 48'h301, AMT_W'(5), 1'b0, 9'h0};
      data_i = w;
      valid_v[0] = 1'b1;
      @(posedge clk); #1;
      valid_v = '0;
      @(posedge clk); #1;
      chk("mid.busy", DATA_W'(busy_v[0]), DATA_W'(1));
      rst_n = 1'b0;
      #1;
      chk_zero(0, "mid_rst");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mid.no_pulse", DATA_W'(vo_v[0] | rj_v[0]), DATA_W'(0));
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      m_id.delete(); m_bal.delete();
      do_txn(0, 48'h300, 48'h301, 5, 1'b0, "post_rst");
      do_txn(0, 48'h200, 48'h300, 96, 1'b0, "post_rst2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
